// File: rtl/somador_param_sm_if.sv
// ============================================================================
// Module      : somador_param_sm_if
// Description : start/busy/done handshake and operand/result bus for the
//               sign-aware adder/subtractor somador_param_sm.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface somador_param_sm_if #(
    parameter int N = 8
) ();
    logic         start;
    logic         mode;
    logic         sub;
    logic [N-1:0] a;
    logic [N-1:0] b;
    logic         busy;
    logic         done;
    logic [N:0]   result;
    logic         ovf;

    modport master (
        output start, mode, sub, a, b,
        input  busy, done, result, ovf
    );

    modport slave (
        input  start, mode, sub, a, b,
        output busy, done, result, ovf
    );
endinterface

`default_nettype wire

// File: rtl/somador_param_sm.sv
// ============================================================================
// Module      : somador_param_sm
// Description : N-bit 2C / sign-magnitude adder-subtractor, 5-cycle FSM.
//               Define SOMADOR_SAT_EN to clamp overflowing results.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module somador_param_sm #(
    parameter int N = 8
) (
    input  wire logic            clk,
    input  wire logic            RESET,
    somador_param_sm_if.slave    bus
);

    localparam logic [2:0] c_idle = 3'd0;
    localparam logic [2:0] c_mag  = 3'd1;
    localparam logic [2:0] c_cmp  = 3'd2;
    localparam logic [2:0] c_op   = 3'd3;
    localparam logic [2:0] c_res  = 3'd4;

    localparam logic [N-1:0] c_one_n  = {{(N-1){1'b0}}, 1'b1};
    localparam logic [N:0]   c_one_n1 = {{N{1'b0}}, 1'b1};
    localparam logic [N:0]   c_max    = {2'b00, {(N-1){1'b1}}};
    localparam logic [N:0]   c_half   = {2'b01, {(N-1){1'b0}}};

    logic [2:0]   r_state;
    logic [2:0]   w_next;

    logic [N-1:0] r_a;
    logic [N-1:0] r_b;
    logic         r_mode;
    logic         r_sub;

    logic         r_sa;
    logic         r_sb;
    logic [N-1:0] r_ma;
    logic [N-1:0] r_mb;

    logic         r_sign;
    logic         r_do_sub;
    logic [N-1:0] r_maior;
    logic [N-1:0] r_menor;

    logic [N:0]   r_mag;

    logic [N:0]   r_result;
    logic         r_ovf;
    logic         r_done;

    logic [N-1:0] w_ma;
    logic [N-1:0] w_mb;
    logic         w_sa;
    logic         w_sb;
    logic         w_a_ge;
    logic         w_neg;
    logic [N:0]   w_2c;
    logic [N:0]   w_sm;
    logic [N:0]   w_exact;
    logic         w_ovf;
    logic [N:0]   w_res;

    // ------------------------------------------------------------------
    // FSM
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge RESET) begin
        if (RESET) begin
            r_state <= c_idle;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            c_idle:  w_next = bus.start ? c_mag : c_idle;
            c_mag:   w_next = c_cmp;
            c_cmp:   w_next = c_op;
            c_op:    w_next = c_res;
            c_res:   w_next = c_idle;
            default: w_next = c_idle;
        endcase
    end

    always_comb begin
        bus.busy   = (r_state != c_idle);
        bus.done   = r_done;
        bus.result = r_result;
        bus.ovf    = r_ovf;
    end

    // ------------------------------------------------------------------
    // Datapath combinational stages
    // ------------------------------------------------------------------
    // 2C magnitude is N bits wide so the most negative value maps to 2^(N-1).
    always_comb begin
        w_ma = r_mode ? {1'b0, r_a[N-2:0]} : (r_a[N-1] ? (~r_a + c_one_n) : r_a);
        w_mb = r_mode ? {1'b0, r_b[N-2:0]} : (r_b[N-1] ? (~r_b + c_one_n) : r_b);
        w_sa = r_a[N-1] & (w_ma != '0);
        w_sb = (r_b[N-1] ^ r_sub) & (w_mb != '0);
    end

    assign w_a_ge = (r_ma >= r_mb);

    always_comb begin
        w_neg   = r_sign & (r_mag != '0);
        w_2c    = w_neg ? (~r_mag + c_one_n1) : r_mag;
        w_sm    = {w_neg, r_mag[N-1:0]};
        w_exact = r_mode ? w_sm : w_2c;
        if (w_neg) begin
            w_ovf = r_mode ? (r_mag > c_max) : (r_mag > c_half);
        end else begin
            w_ovf = (r_mag > c_max);
        end
`ifdef SOMADOR_SAT_EN
        if (w_ovf) begin
            if (r_mode) begin
                w_res = {w_neg, 1'b0, {(N-1){1'b1}}};
            end else begin
                w_res = w_neg ? {2'b11, {(N-1){1'b0}}} : c_max;
            end
        end else begin
            w_res = w_exact;
        end
`else
        w_res = w_exact;
`endif
    end

    // ------------------------------------------------------------------
    // Datapath registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge RESET) begin
        if (RESET) begin
            r_a      <= '0;
            r_b      <= '0;
            r_mode   <= 1'b0;
            r_sub    <= 1'b0;
            r_sa     <= 1'b0;
            r_sb     <= 1'b0;
            r_ma     <= '0;
            r_mb     <= '0;
            r_sign   <= 1'b0;
            r_do_sub <= 1'b0;
            r_maior  <= '0;
            r_menor  <= '0;
            r_mag    <= '0;
            r_result <= '0;
            r_ovf    <= 1'b0;
            r_done   <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                c_idle: begin
                    if (bus.start) begin
                        r_a    <= bus.a;
                        r_b    <= bus.b;
                        r_mode <= bus.mode;
                        r_sub  <= bus.sub;
                    end
                end
                c_mag: begin
                    r_sa <= w_sa;
                    r_sb <= w_sb;
                    r_ma <= w_ma;
                    r_mb <= w_mb;
                end
                c_cmp: begin
                    r_maior  <= w_a_ge ? r_ma : r_mb;
                    r_menor  <= w_a_ge ? r_mb : r_ma;
                    r_sign   <= w_a_ge ? r_sa : r_sb;
                    r_do_sub <= r_sa ^ r_sb;
                end
                c_op: begin
                    // Extra bit keeps the addition carry.
                    r_mag <= r_do_sub ? ({1'b0, r_maior} - {1'b0, r_menor})
                                      : ({1'b0, r_maior} + {1'b0, r_menor});
                end
                c_res: begin
                    r_result <= w_res;
                    r_ovf    <= w_ovf;
                    r_done   <= 1'b1;
                end
                default: ;
            endcase
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_somador_param_sm.sv
// ============================================================================
// Module      : tb_somador_param_sm
// Description : Scoreboard bench for somador_param_sm (N=8).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_somador_param_sm;

    localparam int N = 8;

    logic clk;
    logic RESET;
    int   n_chk;
    int   n_pass;

    somador_param_sm_if #(.N(N)) bus ();

    somador_param_sm #(.N(N)) dut (
        .clk   (clk),
        .RESET (RESET),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Reference: decode to integers, do the arithmetic, re-encode.
    function automatic logic [N:0] ref_res(input logic [N-1:0] a, input logic [N-1:0] b,
                                           input logic mode, input logic sub,
                                           output logic ovf);
        int va, vb, v, maxp, minn, mag;
        logic [31:0] t;
        if (mode) begin
            va = a[N-1] ? -int'(a[N-2:0]) : int'(a[N-2:0]);
            vb = b[N-1] ? -int'(b[N-2:0]) : int'(b[N-2:0]);
        end else begin
            va = int'($signed(a));
            vb = int'($signed(b));
        end
        v    = sub ? va - vb : va + vb;
        maxp = (1 << (N-1)) - 1;
        minn = mode ? -maxp : -maxp - 1;
        ovf  = (v > maxp) || (v < minn);
`ifdef SOMADOR_SAT_EN
        if (v > maxp) v = maxp;
        if (v < minn) v = minn;
`endif
        if (mode) begin
            mag = (v < 0) ? -v : v;
            t   = mag;
            return {(v < 0), t[N-1:0]};
        end else begin
            t = v;
            return t[N:0];
        end
    endfunction

    // Scoreboard and cycle model of the handshake
    int         st;
    logic       exp_done;
    logic [N:0] q_res[$];
    logic       q_ovf[$];

    always @(posedge clk or posedge RESET) begin
        if (RESET) begin
            st       = 0;
            exp_done = 1'b0;
            q_res.delete();
            q_ovf.delete();
        end else begin
            exp_done = (st == 4);
            if (st == 0) begin
                if (bus.start) begin
                    logic       o;
                    logic [N:0] r;
                    r = ref_res(bus.a, bus.b, bus.mode, bus.sub, o);
                    q_res.push_back(r);
                    q_ovf.push_back(o);
                    st = 1;
                end
            end else if (st == 4) begin
                st = 0;
            end else begin
                st = st + 1;
            end
        end
    end

    always @(negedge clk) begin
        if (!RESET) begin
            chk("busy", 32'(bus.busy), 32'(st != 0));
            chk("done", 32'(bus.done), 32'(exp_done));
            chk("busy_done_overlap", 32'(bus.busy & bus.done), 32'd0);
            if (exp_done) begin
                if (q_res.size() == 0) begin
                    chk("scoreboard_empty", 32'd1, 32'd0);
                end else begin
                    logic [N:0] er;
                    logic       eo;
                    er = q_res.pop_front();
                    eo = q_ovf.pop_front();
                    chk("result", 32'(bus.result), 32'(er));
                    chk("ovf", 32'(bus.ovf), 32'(eo));
                end
            end
        end
    end

    task automatic drive(input logic s, input logic [N-1:0] a, input logic [N-1:0] b,
                         input logic m, input logic sb);
        @(negedge clk);
        bus.start = s;
        bus.a     = a;
        bus.b     = b;
        bus.mode  = m;
        bus.sub   = sb;
    endtask

    task automatic drive_rand(input logic s);
        drive(s, N'($urandom), N'($urandom), 1'($urandom), 1'($urandom));
    endtask

    // One op followed by four busy cycles of random stimulus that must be ignored.
    task automatic op(input logic [N-1:0] a, input logic [N-1:0] b, input logic m, input logic sb);
        drive(1'b1, a, b, m, sb);
        repeat (4) drive_rand(1'($urandom));
    endtask

    initial begin
        n_chk     = 0;
        n_pass    = 0;
        RESET     = 1'b1;
        bus.start = 1'b0;
        bus.a     = '0;
        bus.b     = '0;
        bus.mode  = 1'b0;
        bus.sub   = 1'b0;
        repeat (2) @(negedge clk);
        chk("rst_busy", 32'(bus.busy), 32'd0);
        chk("rst_done", 32'(bus.done), 32'd0);
        chk("rst_result", 32'(bus.result), 32'd0);
        chk("rst_ovf", 32'(bus.ovf), 32'd0);
        #2 RESET = 1'b0;

        // Directed vectors, issued back to back
        op(8'h7F, 8'h01, 1'b0, 1'b0);
        op(8'h80, 8'h01, 1'b0, 1'b1);
        op(8'h85, 8'h03, 1'b1, 1'b0);
        op(8'h80, 8'h00, 1'b1, 1'b1);
        op(8'h05, 8'h85, 1'b1, 1'b0);
        op(8'h80, 8'h80, 1'b0, 1'b0);
        op(8'h7F, 8'h80, 1'b0, 1'b1);
        op(8'h7F, 8'h7F, 1'b1, 1'b0);
        op(8'hFF, 8'hFF, 1'b1, 1'b0);
        op(8'h80, 8'h80, 1'b1, 1'b1);
        op(8'h10, 8'h10, 1'b0, 1'b1);
        op(8'h03, 8'h08, 1'b1, 1'b1);

        // start held high, new operands every cycle
        repeat (40) drive_rand(1'b1);
        // Fully random start
        repeat (80) drive_rand(1'($urandom));
        drive(1'b0, '0, '0, 1'b0, 1'b0);
        repeat (6) @(negedge clk);

        // Reset in the second busy cycle of an operation
        drive(1'b1, 8'h7F, 8'h7F, 1'b0, 1'b0);
        drive(1'b0, 8'h00, 8'h00, 1'b0, 1'b0);
        @(negedge clk);
        #2 RESET = 1'b1;
        #1;
        chk("abort_busy", 32'(bus.busy), 32'd0);
        chk("abort_done", 32'(bus.done), 32'd0);
        chk("abort_result", 32'(bus.result), 32'd0);
        chk("abort_ovf", 32'(bus.ovf), 32'd0);
        @(negedge clk);
        #2 RESET = 1'b0;
        repeat (8) @(negedge clk);
        chk("abort_no_late_done", 32'(bus.done), 32'd0);

        // One more op after the abort
        op(8'h85, 8'h03, 1'b1, 1'b0);
        drive(1'b0, '0, '0, 1'b0, 1'b0);
        repeat (6) @(negedge clk);
        chk("scoreboard_drained", 32'(q_res.size()), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

`default_nettype wire
